det3_seq: RTL and testbench
===========================

Name: det3_seq

Overview:
- Sequencer that computes the determinant of a 3x3 signed matrix by cofactor expansion along row 0.
- Uses a single shared 2x2 minor datapath (ad - bc) three times in successive cycles, with one multiply-accumulate per cycle.
- Sits between the coprocessor command decoder (start, matrix operands) and the result register file.
- Returns the full-width determinant plus an overflow flag for consumers that keep only DW bits.

Parameters:
- DW, 8, element width in bits, signed two's complement.
- RW, 3*DW+2, result width; holds the exact determinant for any DW-bit inputs.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request pulse; sampled only in IDLE
- mat  in  9*DW  matrix, element a[r][c] at mat[DW*(3r+c) +: DW]; sampled only on the accepted start cycle
- busy  out  1  high from the cycle after start is accepted through the DONE cycle inclusive
- done  out  1  one-cycle pulse; det and ovf are valid from this cycle onward
- det  out  RW  signed determinant; holds its value until the next done
- ovf  out  1  1 when det lies outside [-2^(DW-1), 2^(DW-1)-1]; updated together with det

Behaviour:
- Reset: state=IDLE, busy=0, done=0, det=0, ovf=0, accumulator=0, latched matrix=0.
- States: IDLE -> M0 -> M1 -> M2 -> DONE -> IDLE.
- IDLE:
  - busy=0.
  - On start=1: latch mat into an internal register, clear the accumulator, go to M0.
- M0: acc <= a00 * (a11*a22 - a12*a21).
- M1: acc <= acc - a01 * (a10*a22 - a12*a20).
- M2: acc <= acc + a02 * (a10*a21 - a11*a20).
- DONE:
  - det <= acc, ovf <= range check of acc, done=1 for this cycle only.
  - Next state is IDLE.
- Latency:
  - start sampled at edge N; done and valid det at edge N+4 (M0, M1, M2, DONE).
  - Throughput is one result per 5 cycles, including the IDLE cycle.
- Arithmetic:
  - Minor computed at 2*DW+1 bits; never truncated. This differs intentionally from the DW-bit truncating 2x2 unit.
  - Products are sign-extended to RW before accumulation.
  - All operations are signed.
  - No saturation: the exact result is always produced.
- Mid-operation input rules:
  - start while busy (M0..DONE) is ignored; no queueing, no error.
  - mat changes while busy have no effect; the latched copy is used.
- Reset at any state forces the reset values on the next edge.
  - A computation in flight is discarded.
  - No done pulse is produced.
- Simultaneous rst and start: rst wins and start is dropped.
- Combinational outputs: busy is decoded from state (registered state, no combinational path from start). done is registered.

Test Plan:
- Identity matrix (a00=a11=a22=1, others 0), start one cycle -> done exactly 4 cycles after start edge, det=1, ovf=0, busy high for 4 cycles.
- [[1,2,3],[0,1,4],[5,6,0]] -> det=1, ovf=0. Then [[2,0,1],[1,3,2],[1,1,1]] -> det=0, ovf=0.
- [[3,8,4],[6,1,2],[5,7,9]] -> det=-219, ovf=1.
- Full-range overflow case:
  - Stimulus: [[127,-128,0],[127,127,0],[0,0,127]].
  - Required: det=4112895 (no wrap in RW=26), ovf=1.
- Busy and input isolation:
  - Assert start again on cycles 1-3 of a run, and change mat mid-run.
  - Required: exactly one done, and the result matches the originally latched matrix.
  - Next start in IDLE is accepted normally.
- Reset behaviour:
  - rst asserted in state M1 -> next cycle busy=0, done=0, det=0, ovf=0, no done pulse.
  - rst and start high together -> no computation starts.

Source files
------------

// File: rtl/det3_seq.sv
// det3_seq: sequential 3x3 signed determinant, cofactor expansion on row 0.
// One shared 2x2 minor and one multiply-accumulate per cycle.
module det3_seq #(
   parameter int DW = 8,
   parameter int RW = 3*DW+2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [9*DW-1:0]      mat,
   output logic                 busy,
   output logic                 done,
   output logic signed [RW-1:0] det,
   output logic                 ovf
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      M0   = 3'd1,
      M1   = 3'd2,
      M2   = 3'd3,
      DONE = 3'd4
   } state_t;

   localparam int MW = 2*DW+1;

   localparam logic signed [RW-1:0] MINV = RW'(-(2**(DW-1)));
   localparam logic signed [RW-1:0] MAXV = RW'(2**(DW-1)-1);

   state_t                 state;
   logic [9*DW-1:0]        m_q;
   logic signed [RW-1:0]   acc;

   logic signed [DW-1:0]   a [9];

   logic signed [DW-1:0]   op_p;
   logic signed [DW-1:0]   op_q;
   logic signed [DW-1:0]   op_r;
   logic signed [DW-1:0]   op_s;
   logic signed [DW-1:0]   op_c;
   logic                   sub;

   logic signed [MW-1:0]   px;
   logic signed [MW-1:0]   qx;
   logic signed [MW-1:0]   rx;
   logic signed [MW-1:0]   sx;
   logic signed [MW-1:0]   pq;
   logic signed [MW-1:0]   rs;
   logic signed [MW-1:0]   minor;

   logic signed [RW-1:0]   cx;
   logic signed [RW-1:0]   mx;
   logic signed [RW-1:0]   prod;
   logic signed [RW-1:0]   acc_nxt;

   // unpack the latched matrix, a[3r+c] = element (r,c)
   always_comb begin
      for (int i = 0; i < 9; i++) begin
         a[i] = m_q[DW*i +: DW];
      end
   end

   // pick minor operands and cofactor sign for the current column
   always_comb begin
      op_p = '0;
      op_q = '0;
      op_r = '0;
      op_s = '0;
      op_c = '0;
      sub  = 1'b0;
      unique case (state)
         M0: begin
            op_p = a[4];
            op_q = a[8];
            op_r = a[5];
            op_s = a[7];
            op_c = a[0];
         end
         M1: begin
            op_p = a[3];
            op_q = a[8];
            op_r = a[5];
            op_s = a[6];
            op_c = a[1];
            sub  = 1'b1;
         end
         M2: begin
            op_p = a[3];
            op_q = a[7];
            op_r = a[4];
            op_s = a[6];
            op_c = a[2];
         end
         default: begin
         end
      endcase
   end

   // full-width minor and product; nothing is truncated
   always_comb begin
      px      = {{(MW-DW){op_p[DW-1]}}, op_p};
      qx      = {{(MW-DW){op_q[DW-1]}}, op_q};
      rx      = {{(MW-DW){op_r[DW-1]}}, op_r};
      sx      = {{(MW-DW){op_s[DW-1]}}, op_s};
      pq      = px * qx;
      rs      = rx * sx;
      minor   = pq - rs;
      cx      = {{(RW-DW){op_c[DW-1]}}, op_c};
      mx      = {{(RW-MW){minor[MW-1]}}, minor};
      prod    = cx * mx;
      acc_nxt = sub ? (acc - prod) : (acc + prod);
   end

   assign busy = (state != IDLE);

   // sequencer: latch, three MAC steps, publish result
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         m_q   <= '0;
         acc   <= '0;
         det   <= '0;
         ovf   <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  m_q   <= mat;
                  acc   <= '0;
                  state <= M0;
               end
            end
            M0: begin
               acc   <= acc_nxt;
               state <= M1;
            end
            M1: begin
               acc   <= acc_nxt;
               state <= M2;
            end
            M2: begin
               acc   <= acc_nxt;
               state <= DONE;
            end
            DONE: begin
               det   <= acc;
               ovf   <= (acc < MINV) || (acc > MAXV);
               done  <= 1'b1;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_det3_seq.sv
// tb_det3_seq: directed vectors for det3_seq.
// Expected results are queued at issue and checked when done appears.
module tb_det3_seq;

   localparam int DW = 8;
   localparam int RW = 3*DW+2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [9*DW-1:0]      mat;
   logic                 busy;
   logic                 done;
   logic signed [RW-1:0] det;
   logic                 ovf;

   typedef struct {
      logic signed [RW-1:0] d;
      logic                 o;
      int                   tag;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   det3_seq #(.DW(DW), .RW(RW)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .mat   (mat),
      .busy  (busy),
      .done  (done),
      .det   (det),
      .ovf   (ovf)
   );

   function automatic logic [9*DW-1:0] pk(
      input int a0, input int a1, input int a2,
      input int a3, input int a4, input int a5,
      input int a6, input int a7, input int a8);
      logic [9*DW-1:0] m;
      int v [9];
      v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
      m = '0;
      for (int i = 0; i < 9; i++) begin
         m[DW*i +: DW] = v[i][DW-1:0];
      end
      return m;
   endfunction

   task automatic chk(input string nm, input longint act, input longint want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, want);
      end
   endtask

   // monitor: every done pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (done) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done det=%0d ovf=%0d", det, ovf);
         end else begin
            mon_e = sbq.pop_front();
            total++;
            if (det !== mon_e.d) begin
               bad++;
               $display("FAIL det_%0d got=%0d want=%0d",
                        mon_e.tag, det, mon_e.d);
            end
            total++;
            if (ovf !== mon_e.o) begin
               bad++;
               $display("FAIL ovf_%0d got=%0d want=%0d",
                        mon_e.tag, ovf, mon_e.o);
            end
         end
      end
   end

   task automatic run(input logic [9*DW-1:0] m, input int d,
                      input logic o, input int tag, input bit noisy);
      exp_t e;
      int   lat;
      int   bc;
      e.d = RW'(d);
      e.o = o;
      e.tag = tag;
      @(negedge clk);
      start = 1'b1;
      mat   = m;
      sbq.push_back(e);
      @(posedge clk);
      lat = 0;
      bc  = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (noisy && i <= 3) begin
            start = 1'b1;
            mat   = ~m ^ {9{8'(i)}};
         end else begin
            start = 1'b0;
         end
         if (busy) bc++;
         if (done) begin
            lat = i;
            break;
         end
      end
      chk($sformatf("latency_%0d", tag), lat, 5);
      chk($sformatf("busy_cycles_%0d", tag), bc, 4);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      mat   = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_det", det, 0);
      chk("rst_ovf", ovf, 0);
      rst = 1'b0;

      run(pk(1,0,0, 0,1,0, 0,0,1), 1, 1'b0, 1, 1'b0);
      run(pk(1,2,3, 0,1,4, 5,6,0), 1, 1'b0, 2, 1'b0);
      run(pk(2,0,1, 1,3,2, 1,1,1), 0, 1'b0, 3, 1'b0);
      run(pk(127,-128,0, 127,127,0, 0,0,127), 4112895, 1'b1, 4, 1'b0);
      run(pk(2,0,0, 0,64,0, 0,0,1), 128, 1'b1, 5, 1'b0);
      run(pk(-128,0,0, 0,1,0, 0,0,1), -128, 1'b0, 6, 1'b0);
      run(pk(127,0,0, 0,1,0, 0,0,1), 127, 1'b0, 7, 1'b0);
      run(pk(2,1,0, 0,3,1, 1,0,2), 13, 1'b0, 8, 1'b1);
      run(pk(-1,0,0, 0,-1,0, 0,0,-1), -1, 1'b0, 9, 1'b0);
      run(pk(3,8,4, 6,1,2, 5,7,9), -219, 1'b1, 10, 1'b0);

      // reset while in M1: result discarded, outputs cleared
      @(negedge clk);
      start = 1'b1;
      mat   = pk(1,0,0, 0,1,0, 0,0,1);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("m1_busy", busy, 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_det", det, 0);
      chk("mid_rst_ovf", ovf, 0);
      repeat (7) @(negedge clk);
      chk("mid_rst_idle", busy, 0);

      // rst and start together: start dropped
      rst   = 1'b1;
      start = 1'b1;
      mat   = pk(1,0,0, 0,1,0, 0,0,1);
      @(posedge clk);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      chk("rst_start_busy", busy, 0);
      repeat (6) @(negedge clk);
      chk("rst_start_det", det, 0);
      chk("rst_start_idle", busy, 0);

      run(pk(1,2,3, 0,1,4, 5,6,0), 1, 1'b0, 11, 1'b0);

      repeat (3) @(negedge clk);
      chk("sb_empty", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
